// File: rtl/pixel_frame_buffer.sv
// -----------------------------------------------------------------------------
// pixel_frame_buffer
//
// Double-buffered frame store for a chain of 24-bit GRB pixels feeding a
// serial LED driver. Pixels are written into a back buffer. A commit
// publishes the back buffer to the front buffer (pixel_data). The publish
// happens only while the downstream serializer reports its reset/latch
// interval (frame_gap), so a frame never tears mid-shift.
//
// Optional feature macro: PIXEL_BRIGHTNESS_EN
//   When defined, a global brightness port exists. Each channel is scaled
//   as (c * (brightness + 1)) >> 8 when it is copied into the front buffer.
//   When undefined, the copy is bit-exact.
//
// Parameters
//   num_pixels : pixels per frame (1..256)
//   AW         : write-address width, max(1, clog2(num_pixels))
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   wr_valid       : pixel write request
//   wr_ready       : write acceptance (high only in FILL)
//   wr_addr        : pixel index
//   wr_data        : pixel colour, G[23:16] R[15:8] B[7:0]
//   commit         : request to publish the back buffer
//   frame_gap      : serializer is in its reset/latch interval
//   brightness     : global scale (only with PIXEL_BRIGHTNESS_EN)
//   pixel_data     : front buffer, pixel i at [i*24+23 : i*24]
//   commit_pending : a commit is waiting for frame_gap or is swapping
//   addr_err       : one-cycle pulse after an accepted out-of-range write
//   frame_count    : completed swaps, wraps at 16 bits
//
// Write handshake: a transfer happens on a rising clk edge where wr_valid
// and wr_ready are both high. wr_ready does not depend on wr_valid. Once
// wr_valid is raised, wr_addr and wr_data stay stable until the transfer.
// -----------------------------------------------------------------------------
module pixel_frame_buffer #(
  parameter int num_pixels = 8,
  localparam int AW = (num_pixels > 1) ? $clog2(num_pixels) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [23:0]                wr_data,
  input  logic                       commit,
  input  logic                       frame_gap,
`ifdef PIXEL_BRIGHTNESS_EN
  input  logic [7:0]                 brightness,
`endif
  output logic [num_pixels*24-1:0]   pixel_data,
  output logic                       commit_pending,
  output logic                       addr_err,
  output logic [15:0]                frame_count
);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WAIT_GAP = 2'd1,
    SWAP     = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [23:0]                back_mem [num_pixels];
  logic [num_pixels*24-1:0]   swap_data;
  logic                       wr_fire;
  logic                       addr_ok;

  assign wr_fire = wr_valid && wr_ready;
  assign addr_ok = (int'(wr_addr) < num_pixels);

`ifdef PIXEL_BRIGHTNESS_EN
  // The product is at most 255*256, so it fits in 16 bits and the result
  // after the shift always fits in 8 bits.
  function automatic logic [7:0] scale_chan(input logic [7:0] c,
                                            input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return 8'(prod >> 8);
  endfunction
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state and handshake outputs
  always_comb begin
    state_next     = state;
    wr_ready       = 1'b0;
    commit_pending = 1'b0;
    unique case (state)
      FILL: begin
        wr_ready = 1'b1;
        if (commit) state_next = WAIT_GAP;
      end
      WAIT_GAP: begin
        commit_pending = 1'b1;
        if (frame_gap) state_next = SWAP;
      end
      SWAP: begin
        commit_pending = 1'b1;
        state_next     = FILL;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Back buffer. A write that lands on the same edge as a commit is still
  // taken, because wr_ready is high in FILL on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_pixels; i++) back_mem[i] <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= wr_fire && !addr_ok;
      if (wr_fire && addr_ok) back_mem[wr_addr] <= wr_data;
    end
  end

  // Front-buffer image that is loaded on the swap edge.
  always_comb begin
    swap_data = '0;
    for (int i = 0; i < num_pixels; i++) begin
`ifdef PIXEL_BRIGHTNESS_EN
      swap_data[i*24 +: 24] = {scale_chan(back_mem[i][23:16], brightness),
                               scale_chan(back_mem[i][15:8],  brightness),
                               scale_chan(back_mem[i][7:0],   brightness)};
`else
      swap_data[i*24 +: 24] = back_mem[i];
`endif
    end
  end

  // Front buffer and frame counter change only on the SWAP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data  <= '0;
      frame_count <= '0;
    end else if (state == SWAP) begin
      pixel_data  <= swap_data;
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule
